// File: rtl/if_stage_pkg.sv
// Shared CPU front-end constants: reset vector, fetch-to-decode bus width and field layout.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF    = 32'h1c000000;
    localparam int          FS_TO_DS_BUS_WD = 64;
    localparam int          BUS_INST_LSB    = 0;
    localparam int          BUS_PC_LSB      = 32;

    function automatic logic [FS_TO_DS_BUS_WD-1:0] pack_fs_bus(input logic [31:0] pc,
                                                              input logic [31:0] inst);
        logic [FS_TO_DS_BUS_WD-1:0] bus;
        bus = '0;
        bus[BUS_PC_LSB +: 32]   = pc;
        bus[BUS_INST_LSB +: 32] = inst;
        return bus;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage signal bundle: instruction SRAM port, redirect input and decode handshake.
interface if_stage_if;
    import if_stage_pkg::*;

    logic                       inst_sram_en;
    logic [31:0]                inst_sram_addr;
    logic [31:0]                inst_sram_rdata;
    logic                       br_taken;
    logic [31:0]                br_target;
    logic                       ds_allowin;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

    modport master (
        output inst_sram_en, inst_sram_addr, fs_to_ds_valid, fs_to_ds_bus,
        input  inst_sram_rdata, br_taken, br_target, ds_allowin
    );

    modport slave (
        input  inst_sram_en, inst_sram_addr, fs_to_ds_valid, fs_to_ds_bus,
        output inst_sram_rdata, br_taken, br_target, ds_allowin
    );

endinterface

// File: rtl/if_stage_fifo.sv
// if_fifo: small instruction buffer with push/pop/flush; DEPTH must be a power of two.
module if_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage is reset too so the head reads as zero while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with one-deep SRAM pipeline, credit-based issue and branch redirect.
// Optional stall counter output enabled by defining IF_STALL_CNT_EN.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.master  fs
`ifdef IF_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]                r_fetch_pc;
    logic [31:0]                r_req_pc;
    logic                       r_inflight;
    logic [CNT_W-1:0]           w_count;
    logic [FS_TO_DS_BUS_WD-1:0] w_head;
    logic                       w_valid;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_space;
    logic                       w_issue;
    logic [31:0]                w_addr;

    assign w_valid = (w_count != '0) & ~fs.br_taken;
    assign w_pop   = w_valid & fs.ds_allowin;
    // A redirect discards whatever response lands in the same cycle.
    assign w_push  = r_inflight & ~fs.br_taken;
    // count + inflight - pop < DEPTH, rearranged to avoid unsigned underflow.
    assign w_space = (int'(w_count) + int'(r_inflight)) < (FIFO_DEPTH + int'(w_pop));
    assign w_issue = ~reset & (fs.br_taken | w_space);
    assign w_addr  = fs.br_taken ? fs.br_target : r_fetch_pc;

    assign fs.inst_sram_en   = w_issue;
    assign fs.inst_sram_addr = w_addr;
    assign fs.fs_to_ds_valid = w_valid;
    assign fs.fs_to_ds_bus   = w_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_fetch_pc <= w_addr + 32'd4;
            r_req_pc   <= w_addr;
            r_inflight <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FS_TO_DS_BUS_WD)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (fs.br_taken),
        .i_data  (pack_fs_bus(r_req_pc, fs.inst_sram_rdata)),
        .o_head  (w_head),
        .o_count (w_count)
    );

`ifdef IF_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (fs.ds_allowin & ~w_valid & (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized allowin/redirect traffic
// against a program-order model of the delivered instruction stream.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h1c000000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    if_stage_if bus_if();

`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    if_stage #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fs    (bus_if)
`ifdef IF_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return (pc * 32'h9e3779b1) ^ 32'h5a5ac3c3;
    endfunction

    // Synchronous SRAM: data one cycle after an accepted request.
    always @(posedge clk) begin
        if (bus_if.inst_sram_en) bus_if.inst_sram_rdata <= inst_of(bus_if.inst_sram_addr);
    end

    int          checks    = 0;
    int          failures  = 0;
    int          delivered = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic [31:0] m_stall;
    bit          prev_stall;
    logic [63:0] prev_bus;
    bit          seen_200;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc     = RPC;
        exp_req    = RPC;
        m_stall    = '0;
        prev_stall = 1'b0;
        prev_bus   = '0;
    endtask

    task automatic check_cycle();
        logic        v, en, br, alw;
        logic [31:0] addr, tgt;
        logic [63:0] bus;
        v    = bus_if.fs_to_ds_valid;
        en   = bus_if.inst_sram_en;
        br   = bus_if.br_taken;
        alw  = bus_if.ds_allowin;
        addr = bus_if.inst_sram_addr;
        tgt  = bus_if.br_target;
        bus  = bus_if.fs_to_ds_bus;
        if (br) begin
            chk("br_valid_low", {63'd0, v}, 64'd0);
            chk("br_issue", {63'd0, en}, 64'd1);
            chk("br_addr", {32'd0, addr}, {32'd0, tgt});
        end else if (en) begin
            chk("seq_addr", {32'd0, addr}, {32'd0, exp_req});
        end
        if (prev_stall && !br) begin
            chk("stall_valid", {63'd0, v}, 64'd1);
            chk("stall_bus", bus, prev_bus);
        end
        if (v) chk("head_bus", bus, {exp_pc, inst_of(exp_pc)});
`ifdef IF_STALL_CNT_EN
        chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_stall});
        if (alw && !v && m_stall != 32'hffffffff) m_stall = m_stall + 32'd1;
`endif
        if (br) begin
            exp_pc  = tgt;
            exp_req = tgt + 32'd4;
        end else begin
            if (v && alw) begin
                delivered++;
                if (bus[63:32] == 32'h1c000200) seen_200 = 1'b1;
                exp_pc = exp_pc + 32'd4;
            end
            if (en) exp_req = exp_req + 32'd4;
        end
        prev_stall = v && !alw;
        prev_bus   = bus;
    endtask

    task automatic step();
        @(negedge clk);
        if (!reset) check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus_if.fs_to_ds_valid && n < 10) begin
            step();
            n++;
        end
        chk(tag, {63'd0, bus_if.fs_to_ds_valid}, 64'd1);
    endtask

    initial begin
        bus_if.br_taken   = 1'b0;
        bus_if.br_target  = '0;
        bus_if.ds_allowin = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", {63'd0, bus_if.inst_sram_en}, 64'd0);
        chk("rst_valid", {63'd0, bus_if.fs_to_ds_valid}, 64'd0);
        chk("rst_bus", bus_if.fs_to_ds_bus, 64'd0);
`ifdef IF_STALL_CNT_EN
        chk("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
        reset = 1'b0;

        // First request right after release, first delivery two cycles later at the earliest.
        #1;
        chk("first_req_en", {63'd0, bus_if.inst_sram_en}, 64'd1);
        chk("first_req_addr", {32'd0, bus_if.inst_sram_addr}, {32'd0, RPC});
        chk("first_valid_c0", {63'd0, bus_if.fs_to_ds_valid}, 64'd0);
        step();
        chk("first_valid_c1", {63'd0, bus_if.fs_to_ds_valid}, 64'd0);
        step();
        wait_valid("first_valid_seen");
        chk("first_pc", {32'd0, bus_if.fs_to_ds_bus[63:32]}, {32'd0, RPC});
        for (int i = 0; i < 6; i++) begin
            chk("stream_valid", {63'd0, bus_if.fs_to_ds_valid}, 64'd1);
            step();
        end

        // Downstream stall fills the buffer and stops issue.
        bus_if.ds_allowin = 1'b0;
        repeat (5) step();
        chk("full_no_issue", {63'd0, bus_if.inst_sram_en}, 64'd0);
        chk("full_valid", {63'd0, bus_if.fs_to_ds_valid}, 64'd1);
        bus_if.ds_allowin = 1'b1;
        repeat (4) step();

        // Redirect while credits are exhausted and a request is in flight.
        bus_if.ds_allowin = 1'b0;
        bus_if.br_taken   = 1'b1;
        bus_if.br_target  = 32'h1c000100;
        #1;
        chk("br_full_valid", {63'd0, bus_if.fs_to_ds_valid}, 64'd0);
        step();
        bus_if.br_taken   = 1'b0;
        bus_if.ds_allowin = 1'b1;
        wait_valid("br_tgt_valid");
        chk("br_tgt_pc", {32'd0, bus_if.fs_to_ds_bus[63:32]}, 64'h1c000100);
        step();
        wait_valid("br_tgt4_valid");
        chk("br_tgt4_pc", {32'd0, bus_if.fs_to_ds_bus[63:32]}, 64'h1c000104);

        // Back-to-back redirects: the second wins.
        seen_200         = 1'b0;
        bus_if.br_taken  = 1'b1;
        bus_if.br_target = 32'h1c000200;
        step();
        bus_if.br_target = 32'h1c000300;
        step();
        bus_if.br_taken  = 1'b0;
        wait_valid("br2_valid");
        chk("br2_pc", {32'd0, bus_if.fs_to_ds_bus[63:32]}, 64'h1c000300);
        repeat (6) step();
        chk("br200_skipped", {63'd0, seen_200}, 64'd0);

        // Sequential address wrap.
        bus_if.br_taken  = 1'b1;
        bus_if.br_target = 32'hfffffffc;
        step();
        bus_if.br_taken  = 1'b0;
        #1;
        chk("wrap_en", {63'd0, bus_if.inst_sram_en}, 64'd1);
        chk("wrap_addr", {32'd0, bus_if.inst_sram_addr}, 64'd0);
        wait_valid("wrap_valid");
        chk("wrap_pc0", {32'd0, bus_if.fs_to_ds_bus[63:32]}, 64'hfffffffc);
        repeat (4) step();

        // Asynchronous reset with a full buffer.
        bus_if.ds_allowin = 1'b0;
        repeat (4) step();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_en", {63'd0, bus_if.inst_sram_en}, 64'd0);
        chk("arst_valid", {63'd0, bus_if.fs_to_ds_valid}, 64'd0);
        chk("arst_bus", bus_if.fs_to_ds_bus, 64'd0);
`ifdef IF_STALL_CNT_EN
        chk("arst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
        model_reset();
        bus_if.ds_allowin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("restart_addr", {32'd0, bus_if.inst_sram_addr}, {32'd0, RPC});
        step();
        step();
        wait_valid("restart_valid");
        chk("restart_pc", {32'd0, bus_if.fs_to_ds_bus[63:32]}, {32'd0, RPC});

        // Randomized traffic against the program-order model.
        delivered = 0;
        for (int i = 0; i < 400; i++) begin
            bus_if.ds_allowin = ($urandom_range(0, 3) != 0);
            bus_if.br_taken   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) bus_if.br_target = $urandom;
            else bus_if.br_target = RPC + ($urandom_range(0, 255) << 2);
            step();
        end
        bus_if.br_taken   = 1'b0;
        bus_if.ds_allowin = 1'b1;
        repeat (6) step();
        chk("progress", {63'd0, (delivered >= 100)}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000, the address of the first instruction fetched after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the instruction buffer entry count (legal values 2 and 4).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port inst_sram_en  output  1  read request to the synchronous instruction SRAM.
REQ-006 SHALL have port inst_sram_addr  output  32  byte address of the request.
REQ-007 SHALL have port inst_sram_rdata  input  32  read data, valid exactly one cycle after an accepted request.
REQ-008 SHALL have port br_taken  input  1  single-cycle redirect pulse from the decode/execute stage.
REQ-009 SHALL have port br_target  input  32  redirect address, sampled only when br_taken=1.
REQ-010 SHALL have port ds_allowin  input  1  downstream ready.
REQ-011 SHALL have port fs_to_ds_valid  output  1  buffer head is valid.
REQ-012 SHALL have port fs_to_ds_bus  output  64  {pc[31:0], inst[31:0]} of the buffer head.

Function
REQ-013 SHALL hold fetch_pc, the next sequential fetch address, and advance it by 4 on each issued sequential request, with 32-bit wrap-around and no overflow flag.
REQ-014 SHALL track inflight (0/1), set on an issued request and cleared when its response is written into the buffer or discarded.
REQ-015 SHALL issue (inst_sram_en=1) when count + inflight - pop < FIFO_DEPTH, where pop = fs_to_ds_valid & ds_allowin (same-cycle pop credit).
REQ-016 SHALL push {request pc, inst_sram_rdata} into the buffer in the cycle after an issued request, unless a redirect occurs in that cycle.
REQ-017 SHALL allow a push and a pop in the same cycle with count unchanged; a push into a full buffer SHALL never occur, because REQ-015 guarantees space.
REQ-018 SHALL drive fs_to_ds_valid = (count != 0) & ~br_taken, and fs_to_ds_bus from the head entry.
REQ-019 SHALL treat a cycle with fs_to_ds_valid=1 and ds_allowin=0 as a stall: head entry and bus held stable.
REQ-020 on br_taken=1 in cycle N, SHALL:
- flush all buffer entries at the N edge;
- discard the response arriving in N;
- issue a request with inst_sram_addr=br_target in N, regardless of space;
- set fetch_pc = br_target + 4.
REQ-021 SHALL drive inst_sram_addr = br_taken ? br_target : fetch_pc.
REQ-022 SHALL let a second br_taken in cycle N+1 override the first: the N+1 response is discarded and the N+1 target is fetched.
REQ-023 SHALL pass br_target[1:0] through unmodified; alignment checking is owned downstream.
REQ-024 SHALL deliver the first instruction at RESET_PC with fs_to_ds_valid=1 no earlier than two cycles after reset deasserts.

Reset
REQ-025 during reset, SHALL set inst_sram_en=0, fs_to_ds_valid=0, count=0, inflight=0, fetch_pc=RESET_PC, fs_to_ds_bus=0.
REQ-026 SHALL, when reset is asserted mid-operation, immediately clear all state to REQ-025 values and drop any pending SRAM response.
REQ-027 SHALL issue the first request in the first clk edge-cycle after reset deasserts, with inst_sram_addr=RESET_PC.

Configuration
REQ-028 SHALL, with macro IF_STALL_CNT_EN defined, add output stall_cnt (32-bit, reset 0) counting cycles where ds_allowin=1 and fs_to_ds_valid=0, saturating at 32'hffffffff.
REQ-029 SHALL, without IF_STALL_CNT_EN, omit the stall_cnt port and counter logic entirely.

Structure
REQ-030 SHALL take RESET_PC default value, FS_TO_DS_BUS_WD (64), and the bus field offsets from the shared CPU package.
REQ-031 SHALL implement the buffer as a sub-module if_fifo (parameterized depth, push/pop/flush, count output); fetch control stays in if_stage.

Verification
REQ-032 Reset release, ds_allowin=1 constant -> requests at 1c000000, 1c000004, ...; first fs_to_ds_valid=1 with pc=1c000000; one instruction per cycle thereafter.
REQ-033 ds_allowin=0 for 5 cycles -> count reaches FIFO_DEPTH, inst_sram_en=0, head bus stable; on release, no instruction lost or duplicated.
REQ-034 br_taken=1, br_target=1c000100 while buffer full and a request is in flight -> fs_to_ds_valid=0 that cycle, next delivered pc=1c000100, then 1c000104.
REQ-035 br_taken in two consecutive cycles (targets 1c000200, 1c000300) -> the 1c000200 instruction is never delivered; next delivered pc=1c000300.
REQ-036 fetch_pc=fffffffc sequential -> next request addr 00000000.
REQ-037 reset asserted mid-stream with count=2 -> outputs zero asynchronously; after release, fetch restarts at RESET_PC; with IF_STALL_CNT_EN, stall_cnt=0.
